// File: rtl/fmt_drive_bank_pkg.sv
// Shared types for fmt_drive_bank: pin format codes and the per-pin drive update helper.
package fmt_bank_pkg;

  localparam int FMT_W = 2;

  typedef enum logic [FMT_W-1:0] {
    FMT_NRZ  = 2'd0,
    FMT_RZ   = 2'd1,
    FMT_R1   = 2'd2,
    FMT_DNRZ = 2'd3
  } fmt_t;

  // Next pin level; the trailing edge outranks the leading edge so L==T never glitches.
  function automatic logic fmt_next(input fmt_t f, input logic a, input logic q,
                                    input logic boundary, input logic lead_hit,
                                    input logic trail_hit);
    logic n;
    n = q;
    case (f)
      FMT_NRZ: begin
        if (boundary) n = a;
        else          n = q;
      end
      FMT_RZ: begin
        if (trail_hit)     n = 1'b0;
        else if (lead_hit) n = a;
        else               n = q;
      end
      FMT_R1: begin
        if (trail_hit)     n = 1'b1;
        else if (lead_hit) n = a;
        else               n = q;
      end
      FMT_DNRZ: begin
        if (lead_hit) n = a;
        else          n = q;
      end
      default: n = q;
    endcase
    return n;
  endfunction

endpackage

// File: rtl/fmt_drive_bank_if.sv
// Sequencer <-> formatter bank bus. The OVR overrun flag exists only when FMT_BANK_OVR_EN is defined.
interface fmt_drive_bank_if #(
  parameter int NCH   = 8,
  parameter int TW    = 8,
  parameter int NSETS = 4,
  parameter int SEL_W = 2
);
  logic                  EN;
  logic                  LOAD;
  logic [NCH-1:0]        D;
  logic [2*NCH-1:0]      FMT;
  logic                  TRANSFER;
  logic [SEL_W-1:0]      TSET_SEL;
  logic [NSETS*TW-1:0]   LEAD;
  logic [NSETS*TW-1:0]   TRAIL;
  logic [TW-1:0]         CYCLE_LENGTH;
  logic [NCH-1:0]        Q;
  logic                  CYC_START;
  logic                  PENDING;
`ifdef FMT_BANK_OVR_EN
  logic                  OVR;

  modport master (output EN, LOAD, D, FMT, TRANSFER, TSET_SEL, LEAD, TRAIL, CYCLE_LENGTH,
                  input  Q, CYC_START, PENDING, OVR);
  modport slave  (input  EN, LOAD, D, FMT, TRANSFER, TSET_SEL, LEAD, TRAIL, CYCLE_LENGTH,
                  output Q, CYC_START, PENDING, OVR);
`else
  modport master (output EN, LOAD, D, FMT, TRANSFER, TSET_SEL, LEAD, TRAIL, CYCLE_LENGTH,
                  input  Q, CYC_START, PENDING);
  modport slave  (input  EN, LOAD, D, FMT, TRANSFER, TSET_SEL, LEAD, TRAIL, CYCLE_LENGTH,
                  output Q, CYC_START, PENDING);
`endif
endinterface

// File: rtl/fmt_drive_bank_chan.sv
// One pin channel: shadow/active data+format registers and the registered pin drive.
module fmt_chan
  import fmt_bank_pkg::*;
(
  input  logic CLK,
  input  logic RST,
  input  logic load,
  input  logic commit,
  input  logic boundary,
  input  logic lead_hit,
  input  logic trail_hit,
  input  logic d,
  input  fmt_t fmt,
  output logic q
);

  logic shadow_data_q, shadow_data_d;
  fmt_t shadow_fmt_q,  shadow_fmt_d;
  logic act_data_q,    act_data_d;
  fmt_t act_fmt_q,     act_fmt_d;
  logic pin_q,         pin_d;

  // A commit uses the pre-load shadow; edges this clock already see the committed value.
  always_comb begin
    shadow_data_d = shadow_data_q;
    shadow_fmt_d  = shadow_fmt_q;
    if (load) begin
      shadow_data_d = d;
      shadow_fmt_d  = fmt;
    end else begin
      shadow_data_d = shadow_data_q;
      shadow_fmt_d  = shadow_fmt_q;
    end
    if (commit) begin
      act_data_d = shadow_data_q;
      act_fmt_d  = shadow_fmt_q;
    end else begin
      act_data_d = act_data_q;
      act_fmt_d  = act_fmt_q;
    end
    pin_d = fmt_next(act_fmt_d, act_data_d, pin_q, boundary, lead_hit, trail_hit);
  end

  // Channel state registers.
  always_ff @(posedge CLK) begin
    if (!RST) begin
      shadow_data_q <= 1'b0;
      shadow_fmt_q  <= FMT_NRZ;
      act_data_q    <= 1'b0;
      act_fmt_q     <= FMT_NRZ;
      pin_q         <= 1'b0;
    end else begin
      shadow_data_q <= shadow_data_d;
      shadow_fmt_q  <= shadow_fmt_d;
      act_data_q    <= act_data_d;
      act_fmt_q     <= act_fmt_d;
      pin_q         <= pin_d;
    end
  end

  assign q = pin_q;

endmodule

// File: rtl/fmt_drive_bank.sv
// Multi-pin double-buffered formatter bank sharing one test-cycle counter and NSETS timing sets.
// Optional FMT_BANK_OVR_EN adds the sticky OVR (shadow overwritten while a commit is pending).
module fmt_drive_bank
  import fmt_bank_pkg::*;
#(
  parameter int NCH   = 8,
  parameter int TW    = 8,
  parameter int NSETS = 4,
  parameter int SEL_W = 2
) (
  input  logic             CLK,
  input  logic             RST,
  fmt_drive_bank_if.slave  bus
);

  logic [TW-1:0]    cnt_q, cnt_d;
  logic [SEL_W-1:0] set_q, set_d;
  logic             pending_q, pending_d;
  logic             cyc_start_q, cyc_start_d;
  logic             boundary_s, commit_s, sel_ok_s;
  logic             lead_hit_s, trail_hit_s;
  logic [SEL_W-1:0] set_eff_s;
  logic [TW-1:0]    lead_s, trail_s;
  logic [NCH-1:0]   q_s;

  if ((1 << SEL_W) == NSETS) begin : g_sel_full
    assign sel_ok_s = 1'b1;
  end else begin : g_sel_part
    assign sel_ok_s = (32'(bus.TSET_SEL) < NSETS);
  end

  // Counter, boundary/commit decode, timing-set pick and edge compare.
  always_comb begin
    boundary_s = bus.EN && (cnt_q == {TW{1'b0}});
    commit_s   = boundary_s && (pending_q || bus.TRANSFER);

    if (boundary_s) begin
      if (sel_ok_s) set_eff_s = bus.TSET_SEL;
      else          set_eff_s = {SEL_W{1'b0}};
    end else begin
      set_eff_s = set_q;
    end
    set_d = set_eff_s;

    lead_s      = bus.LEAD[32'(set_eff_s) * TW +: TW];
    trail_s     = bus.TRAIL[32'(set_eff_s) * TW +: TW];
    lead_hit_s  = bus.EN && (lead_s < bus.CYCLE_LENGTH) && (cnt_q == lead_s);
    trail_hit_s = bus.EN && (trail_s < bus.CYCLE_LENGTH) && (cnt_q == trail_s);

    // CYCLE_LENGTH of 0 or 1 pins the counter at 0 (every enabled clock is a boundary).
    if (!bus.EN) begin
      cnt_d = cnt_q;
    end else if ((bus.CYCLE_LENGTH <= TW'(1'b1)) || (cnt_q >= bus.CYCLE_LENGTH - TW'(1'b1))) begin
      cnt_d = {TW{1'b0}};
    end else begin
      cnt_d = cnt_q + TW'(1'b1);
    end

    if (boundary_s)        pending_d = 1'b0;
    else if (bus.TRANSFER) pending_d = 1'b1;
    else                   pending_d = pending_q;

    cyc_start_d = boundary_s;
  end

  // Shared control registers.
  always_ff @(posedge CLK) begin
    if (!RST) begin
      cnt_q       <= {TW{1'b0}};
      set_q       <= {SEL_W{1'b0}};
      pending_q   <= 1'b0;
      cyc_start_q <= 1'b0;
    end else begin
      cnt_q       <= cnt_d;
      set_q       <= set_d;
      pending_q   <= pending_d;
      cyc_start_q <= cyc_start_d;
    end
  end

  for (genvar i = 0; i < NCH; i++) begin : g_chan
    fmt_chan u_chan (
      .CLK       (CLK),
      .RST       (RST),
      .load      (bus.LOAD),
      .commit    (commit_s),
      .boundary  (boundary_s),
      .lead_hit  (lead_hit_s),
      .trail_hit (trail_hit_s),
      .d         (bus.D[i]),
      .fmt       (fmt_t'(bus.FMT[FMT_W*i +: FMT_W])),
      .q         (q_s[i])
    );
  end

  assign bus.Q         = q_s;
  assign bus.CYC_START = cyc_start_q;
  assign bus.PENDING   = pending_q;

`ifdef FMT_BANK_OVR_EN
  logic ovr_q, ovr_d;

  // Overrun: shadow rewritten while an earlier transfer is still waiting.
  always_comb begin
    ovr_d = ovr_q | (bus.LOAD & pending_q);
  end

  // Sticky overrun flag, cleared only by reset.
  always_ff @(posedge CLK) begin
    if (!RST) ovr_q <= 1'b0;
    else      ovr_q <= ovr_d;
  end

  assign bus.OVR = ovr_q;
`endif

endmodule

// File: tb/tb_fmt_drive_bank.sv
// Bench for fmt_drive_bank: table of per-format waveforms plus hand sequences for hold/reset/overrun.
module tb_fmt_drive_bank;

  logic clk = 1'b0;
  logic rst;
  int   n_vec = 0;
  int   n_err = 0;

  always #5 clk = ~clk;

  fmt_drive_bank_if #(.NCH(8), .TW(8), .NSETS(4), .SEL_W(2)) bus ();

  fmt_drive_bank #(.NCH(8), .TW(8), .NSETS(4), .SEL_W(2)) dut (
    .CLK (clk),
    .RST (rst),
    .bus (bus)
  );

  typedef struct {
    string      name;
    logic [1:0] fmt;
    logic       a1;
    logic       a2;
    logic [7:0] l0, t0, l1, t1, cl;
    logic [1:0] sel2;
    logic [19:0] q_wave;
    logic [19:0] pend_wave;
    logic [19:0] cs_wave;
  } vec_t;

  typedef struct {
    logic [7:0] q;
    logic       pend;
    logic       cs;
    string      tag;
  } exp_t;

  exp_t sb[$];
  vec_t vt[11];

  localparam logic [19:0] PD = 20'h003E0;
  localparam logic [19:0] CS = 20'h00401;

  task automatic check(input string nm, input logic [7:0] act, input logic [7:0] req);
    n_vec++;
    if (act !== req) begin
      n_err++;
      $display("FAIL %s: got %h, want %h", nm, act, req);
    end
  endtask

  // Expected values are queued before the edge and retired after it.
  task automatic step(input string tag, input logic eq, input logic ep, input logic ec);
    exp_t e;
    exp_t got;
    e.q = {8{eq}};
    e.pend = ep;
    e.cs = ec;
    e.tag = tag;
    sb.push_back(e);
    @(posedge clk);
    #1;
    got = sb.pop_front();
    check({got.tag, "/Q"}, bus.Q, got.q);
    check({got.tag, "/PENDING"}, {7'd0, bus.PENDING}, {7'd0, got.pend});
    check({got.tag, "/CYC_START"}, {7'd0, bus.CYC_START}, {7'd0, got.cs});
  endtask

  // Reset, program timing, then LOAD+TRANSFER with EN low so the first boundary commits.
  task automatic configure(input vec_t v);
    rst = 1'b0;
    bus.EN = 1'b0; bus.LOAD = 1'b0; bus.TRANSFER = 1'b0;
    @(posedge clk);
    #1;
    rst = 1'b1;
    bus.LEAD  = {8'd0, 8'd0, v.l1, v.l0};
    bus.TRAIL = {8'd0, 8'd0, v.t1, v.t0};
    bus.CYCLE_LENGTH = v.cl;
    bus.TSET_SEL = 2'd0;
    bus.D = {8{v.a1}};
    bus.FMT = {8{v.fmt}};
    bus.LOAD = 1'b1;
    bus.TRANSFER = 1'b1;
    step({v.name, "/setup"}, 1'b0, 1'b1, 1'b0);
    bus.LOAD = 1'b0;
    bus.TRANSFER = 1'b0;
    bus.EN = 1'b1;
  endtask

  initial begin
    logic [7:0] q_exp;
    rst = 1'b0;
    bus.EN = 1'b0; bus.LOAD = 1'b0; bus.TRANSFER = 1'b0;
    bus.D = 8'h00; bus.FMT = 16'h0000; bus.TSET_SEL = 2'd0;
    bus.LEAD = 32'h0; bus.TRAIL = 32'h0; bus.CYCLE_LENGTH = 8'd10;

    vt[0]  = '{"nrz",        2'd0, 1'b1, 1'b0, 8'd3,  8'd7,  8'd0, 8'd0, 8'd10, 2'd0, 20'h003FF, PD, CS};
    vt[1]  = '{"rz",         2'd1, 1'b1, 1'b0, 8'd3,  8'd7,  8'd0, 8'd0, 8'd10, 2'd0, 20'h00078, PD, CS};
    vt[2]  = '{"r1",         2'd2, 1'b1, 1'b0, 8'd3,  8'd7,  8'd0, 8'd0, 8'd10, 2'd0, 20'hE1FF8, PD, CS};
    vt[3]  = '{"dnrz",       2'd3, 1'b1, 1'b0, 8'd3,  8'd7,  8'd0, 8'd0, 8'd10, 2'd0, 20'h01FF8, PD, CS};
    vt[4]  = '{"rz_l_eq_t",  2'd1, 1'b1, 1'b1, 8'd4,  8'd4,  8'd0, 8'd0, 8'd10, 2'd0, 20'h00000, PD, CS};
    vt[5]  = '{"dnrz_l_oor", 2'd3, 1'b1, 1'b1, 8'd12, 8'd7,  8'd0, 8'd0, 8'd10, 2'd0, 20'h00000, PD, CS};
    vt[6]  = '{"r1_l_oor",   2'd2, 1'b1, 1'b1, 8'd12, 8'd7,  8'd0, 8'd0, 8'd10, 2'd0, 20'hFFF80, PD, CS};
    vt[7]  = '{"r1_t_oor",   2'd2, 1'b0, 1'b1, 8'd2,  8'd12, 8'd0, 8'd0, 8'd10, 2'd0, 20'hFF000, PD, CS};
    vt[8]  = '{"nrz_cl0",    2'd0, 1'b1, 1'b0, 8'd3,  8'd7,  8'd0, 8'd0, 8'd0,  2'd0, 20'hFFFFF, 20'h00000, 20'hFFFFF};
    vt[9]  = '{"rz_l0",      2'd1, 1'b1, 1'b0, 8'd0,  8'd5,  8'd0, 8'd0, 8'd10, 2'd0, 20'h0001F, PD, CS};
    vt[10] = '{"rz_tsel",    2'd1, 1'b1, 1'b1, 8'd3,  8'd7,  8'd1, 8'd8, 8'd10, 2'd1, 20'h3F878, PD, CS};

    // Reset held with busy inputs: outputs stay at reset values, counter starts at 0.
    bus.EN = 1'b1; bus.LOAD = 1'b1; bus.TRANSFER = 1'b1; bus.FMT = 16'h5555;
    for (int k = 0; k < 2; k++) begin
      bus.D = (k == 0) ? 8'hA5 : 8'h5A;
      bus.TSET_SEL = 2'(k + 1);
      step($sformatf("reset%0d", k), 1'b0, 1'b0, 1'b0);
    end
    rst = 1'b1; bus.LOAD = 1'b0; bus.TRANSFER = 1'b0; bus.TSET_SEL = 2'd0;
    step("reset_release", 1'b0, 1'b0, 1'b1);
    step("reset_cnt1", 1'b0, 1'b0, 1'b0);

    // Table: 20 clocks per record; a2 loaded and transferred mid-cycle at cnt 5.
    for (int r = 0; r < 11; r++) begin
      configure(vt[r]);
      for (int j = 0; j < 20; j++) begin
        if (j == 5) begin
          bus.LOAD = 1'b1; bus.TRANSFER = 1'b1; bus.D = {8{vt[r].a2}};
        end else begin
          bus.LOAD = 1'b0; bus.TRANSFER = 1'b0;
        end
        if (j >= 4) bus.TSET_SEL = vt[r].sel2;
        step($sformatf("%s/j%0d", vt[r].name, j), vt[r].q_wave[j], vt[r].pend_wave[j], vt[r].cs_wave[j]);
      end
    end

    // EN hold mid-cycle freezes cnt/Q but still takes TRANSFER; then reset drops pending.
    configure(vt[1]);
    q_exp = 8'b0001_1000;
    for (int j = 0; j < 5; j++) step($sformatf("hold/pre%0d", j), q_exp[j], 1'b0, (j == 0));
    bus.EN = 1'b0; bus.TRANSFER = 1'b1;
    step("hold/xfer", 1'b1, 1'b1, 1'b0);
    bus.TRANSFER = 1'b0;
    for (int j = 0; j < 3; j++) step($sformatf("hold/frz%0d", j), 1'b1, 1'b1, 1'b0);
    bus.EN = 1'b1;
    q_exp = 8'b0000_0011;
    for (int j = 0; j < 5; j++) step($sformatf("hold/post%0d", j + 5), q_exp[j], 1'b1, 1'b0);
    step("hold/commit", 1'b0, 1'b0, 1'b1);
    bus.TRANSFER = 1'b1;
    step("hold/xfer2", 1'b0, 1'b1, 1'b0);
    bus.TRANSFER = 1'b0; rst = 1'b0;
    step("midrst", 1'b0, 1'b0, 1'b0);
    rst = 1'b1;
    step("midrst/release", 1'b0, 1'b0, 1'b1);

`ifdef FMT_BANK_OVR_EN
    // Overrun: LOAD while PENDING sets OVR, which holds until reset.
    configure(vt[1]);
    check("ovr/after_setup", {7'd0, bus.OVR}, 8'd0);
    bus.EN = 1'b0; bus.LOAD = 1'b1;
    step("ovr/load_pending", 1'b0, 1'b1, 1'b0);
    check("ovr/set", {7'd0, bus.OVR}, 8'd1);
    bus.LOAD = 1'b0; bus.EN = 1'b1;
    step("ovr/commit", 1'b0, 1'b0, 1'b1);
    check("ovr/sticky", {7'd0, bus.OVR}, 8'd1);
    rst = 1'b0;
    step("ovr/reset", 1'b0, 1'b0, 1'b0);
    check("ovr/cleared", {7'd0, bus.OVR}, 8'd0);
    rst = 1'b1;
`endif

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
